// File: rtl/sid_adsr.sv
// SID-style ADSR envelope generator for one voice: 15-bit rate counter,
// piecewise-exponential decay/release divider and an attack/decay-sustain/release FSM.
module sid_adsr #(
  parameter logic [4:0] BASE_ADDR = 5'd0,
  parameter logic       EXP_MODE  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       WR,
  input  logic [4:0] ADDR,
  input  logic [7:0] DATA,
  output logic [7:0] OUTPUT,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    ST_ATTACK        = 2'd0,
    ST_DECAY_SUSTAIN = 2'd1,
    ST_RELEASE       = 2'd2
  } state_e;

  localparam logic [4:0] A_CTRL = BASE_ADDR + 5'd4;
  localparam logic [4:0] A_AD   = BASE_ADDR + 5'd5;
  localparam logic [4:0] A_SR   = BASE_ADDR + 5'd6;

  state_e      r_state;
  logic [7:0]  r_level;
  logic [14:0] r_rate_cnt;
  logic [4:0]  r_exp_cnt;
  logic        r_gate, r_gate_q;
  logic [3:0]  r_att, r_dec, r_sus, r_rel;

  state_e      w_state_nxt;
  logic [7:0]  w_level_nxt;
  logic [4:0]  w_exp_nxt;
  logic [14:0] w_rate_nxt;
  logic [3:0]  w_nib;
  logic [14:0] w_period;
  logic [4:0]  w_exp_period;
  logic        w_rate_hit, w_step, w_exp_hit, w_rise, w_fall;

  function automatic logic [14:0] rate_period(input logic [3:0] nib);
    case (nib)
      4'd0:    rate_period = 15'd9;
      4'd1:    rate_period = 15'd32;
      4'd2:    rate_period = 15'd63;
      4'd3:    rate_period = 15'd95;
      4'd4:    rate_period = 15'd149;
      4'd5:    rate_period = 15'd220;
      4'd6:    rate_period = 15'd267;
      4'd7:    rate_period = 15'd313;
      4'd8:    rate_period = 15'd392;
      4'd9:    rate_period = 15'd977;
      4'd10:   rate_period = 15'd1954;
      4'd11:   rate_period = 15'd3126;
      4'd12:   rate_period = 15'd3907;
      4'd13:   rate_period = 15'd11720;
      4'd14:   rate_period = 15'd19532;
      default: rate_period = 15'd31251;
    endcase
  endfunction

  // The gate as seen by the envelope lags the register by one edge, so a write
  // at edge N produces its edge event at N+1.
  assign w_rise = r_gate & ~r_gate_q;
  assign w_fall = ~r_gate & r_gate_q;

  // NOTE: every signal gets a default before any branch, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_nib        = r_rel;
    w_exp_period = 5'd1;
    case (r_state)
      ST_ATTACK:        w_nib = r_att;
      ST_DECAY_SUSTAIN: w_nib = r_dec;
      default:          w_nib = r_rel;
    endcase
    if (EXP_MODE) begin
      if      (r_level > 8'd93) w_exp_period = 5'd1;
      else if (r_level >= 8'd55) w_exp_period = 5'd2;
      else if (r_level >= 8'd27) w_exp_period = 5'd4;
      else if (r_level >= 8'd15) w_exp_period = 5'd8;
      else if (r_level >= 8'd7)  w_exp_period = 5'd16;
      else if (r_level >= 8'd1)  w_exp_period = 5'd30;
      else                       w_exp_period = 5'd1;
    end
  end

  assign w_period   = rate_period(w_nib);
  // Equality only: a shrunken period lets the counter run through 0x7FFF.
  assign w_rate_hit = (r_rate_cnt == w_period - 15'd1);
  assign w_step     = TICK & w_rate_hit;
  assign w_rate_nxt = !TICK ? r_rate_cnt : (w_rate_hit ? 15'd0 : r_rate_cnt + 15'd1);
  assign w_exp_hit  = (r_exp_cnt == w_exp_period - 5'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_exp_nxt   = r_exp_cnt;
    if (w_rise) begin
      w_state_nxt = ST_ATTACK;
      w_exp_nxt   = 5'd0;
    end else if (w_fall) begin
      w_state_nxt = ST_RELEASE;
    end else if (w_step) begin
      case (r_state)
        ST_ATTACK: begin
          if (r_level >= 8'hFE) begin
            w_level_nxt = 8'hFF;
            w_state_nxt = ST_DECAY_SUSTAIN;
            w_exp_nxt   = 5'd0;
          end else begin
            w_level_nxt = r_level + 8'd1;
          end
        end
        default: begin
          w_exp_nxt = w_exp_hit ? 5'd0 : r_exp_cnt + 5'd1;
          if (w_exp_hit) begin
            if (r_state == ST_DECAY_SUSTAIN) begin
              if (r_level > {r_sus, r_sus}) w_level_nxt = r_level - 8'd1;
            end else if (r_level != 8'd0) begin
              w_level_nxt = r_level - 8'd1;
            end
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_RELEASE;
      r_level    <= 8'd0;
      r_rate_cnt <= 15'd0;
      r_exp_cnt  <= 5'd0;
      r_gate     <= 1'b0;
      r_gate_q   <= 1'b0;
      r_att      <= 4'd0;
      r_dec      <= 4'd0;
      r_sus      <= 4'hF;
      r_rel      <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_rate_cnt <= w_rate_nxt;
      r_exp_cnt  <= w_exp_nxt;
      r_gate_q   <= r_gate;
      if (WR && ADDR == A_CTRL) r_gate <= DATA[0];
      if (WR && ADDR == A_AD) begin
        r_att <= DATA[7:4];
        r_dec <= DATA[3:0];
      end
      if (WR && ADDR == A_SR) begin
        r_sus <= DATA[7:4];
        r_rel <= DATA[3:0];
      end
    end
  end

  assign OUTPUT = r_level;
  assign STATE  = r_state;

endmodule
